// File: rtl/cpu_board_monitor.sv
// Board front end: debounced step clock for the CPU plus a 4-digit 7-segment debug display.
// Optional auto-run step divider is enabled by defining CPU_MONITOR_AUTO_EN.
module cpu_board_monitor #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SCAN_DIV        = 100000,
  parameter int AUTO_DIV        = 25000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  mode,
  input  logic [31:0] curPC,
  input  logic [31:0] nextPC,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] Out1,
  input  logic [31:0] Out2,
  input  logic [31:0] Result,
  input  logic [31:0] DBData,
`ifdef CPU_MONITOR_AUTO_EN
  input  logic        run_auto,
`endif
  output logic        step_clk,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          s1, s2, db;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit, digit_nxt;
  logic [15:0]   snap, snap_nxt, word;
  logic [3:0]    nib;
  logic [6:0]    seg_hex;
  logic          scan_last;

  // Only the low byte of each wide bus is displayed.
  logic unused_bits;
  assign unused_bits = ^{curPC[31:8], nextPC[31:8], Out1[31:8], Out2[31:8],
                         Result[31:8], DBData[31:8]};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn_step;
      s2 <= s1;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db     <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef CPU_MONITOR_AUTO_EN
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  logic [AW-1:0] auto_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      auto_cnt <= '0;
      step_clk <= 1'b0;
    end else if (run_auto) begin
      if (auto_cnt == AW'(AUTO_DIV - 1)) begin
        auto_cnt <= '0;
        step_clk <= ~step_clk;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end else begin
      auto_cnt <= '0;
      step_clk <= db;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (Reset) step_clk <= 1'b0;
    else       step_clk <= db;
  end
`endif

  always_comb begin
    word = '0;
    unique case (mode)
      2'b00: word = {curPC[7:0], nextPC[7:0]};
      2'b01: word = {3'b0, rs, Out1[7:0]};
      2'b10: word = {3'b0, rt, Out2[7:0]};
      2'b11: word = {Result[7:0], DBData[7:0]};
    endcase
  end

  // AN/SEG are registered from next-state values so they move on the same edge as the index.
  always_comb begin
    scan_last = (scan_cnt == SW'(SCAN_DIV - 1));
    digit_nxt = scan_last ? digit + 2'd1 : digit;
    snap_nxt  = (scan_last && digit == 2'd3) ? word : snap;
    nib       = snap_nxt[digit_nxt*4 +: 4];
  end

  always_comb begin
    seg_hex = 7'h7F;
    unique case (nib)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      4'hF: seg_hex = 7'h0E;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      snap     <= '0;
      AN       <= 4'b1111;
      SEG      <= 8'hFF;
    end else begin
      scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
      digit    <= digit_nxt;
      snap     <= snap_nxt;
      AN       <= ~(4'b0001 << digit_nxt);
      SEG      <= {1'b1, seg_hex};
    end
  end
endmodule

// File: tb/tb_cpu_board_monitor.sv
// Directed bench for cpu_board_monitor with DEBOUNCE_CYCLES=4, SCAN_DIV=2, AUTO_DIV=3.
module tb_cpu_board_monitor;
  logic        CLK, Reset, btn_step;
  logic [1:0]  mode;
  logic [31:0] curPC, nextPC, Out1, Out2, Result, DBData;
  logic [4:0]  rs, rt;
  logic        run_auto;
  logic        step_clk;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int n_chk = 0;
  int n_err = 0;
  int rises = 0;
  int r0;
  logic [7:0] pat;

  cpu_board_monitor #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .AUTO_DIV(3)) dut (
    .CLK(CLK), .Reset(Reset), .btn_step(btn_step), .mode(mode),
    .curPC(curPC), .nextPC(nextPC), .rs(rs), .rt(rt), .Out1(Out1), .Out2(Out2),
    .Result(Result), .DBData(DBData),
`ifdef CPU_MONITOR_AUTO_EN
    .run_auto(run_auto),
`endif
    .step_clk(step_clk), .AN(AN), .SEG(SEG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge step_clk) rises++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance until the display wraps from digit 3 to digit 0.
  task automatic wait_wrap();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = AN;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev == 4'b0111 && AN == 4'b1110) begin
        found = 1;
        break;
      end
      prev = AN;
    end
    if (!found) chk("wrap_timeout", 0, 1);
  endtask

  task automatic dig(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    chk({tag, "_an"}, AN, an_exp);
    chk({tag, "_seg"}, SEG, seg_exp);
  endtask

  initial begin
    Reset = 1'b1; btn_step = 1'b0; mode = 2'b00; run_auto = 1'b0;
    curPC = 0; nextPC = 0; Out1 = 0; Out2 = 0; Result = 0; DBData = 0; rs = 0; rt = 0;

    // Reset and first digit
    repeat (3) tick();
    chk("rst_step", step_clk, 0);
    chk("rst_an", AN, 4'b1111);
    chk("rst_seg", SEG, 8'hFF);
    Reset = 1'b0;
    tick();
    dig("first", 4'b1110, 8'hC0);

    // Clean press: rise on edge 7, fall 7 edges after release
    r0 = rises;
    btn_step = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 6) chk("press_e6", step_clk, 0);
      if (k == 7) chk("press_e7", step_clk, 1);
    end
    btn_step = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("rel_e6", step_clk, 1);
      if (k == 7) chk("rel_e7", step_clk, 0);
    end
    chk("press_rises", rises - r0, 1);

    // Bounce: steady 1 starts at pattern position 6, rise on edge 12
    r0 = rises;
    pat = 8'b1110_1101; // bit0 first: 1,0,1,1,0,1,1,1
    for (int e = 1; e <= 12; e++) begin
      btn_step = (e <= 8) ? pat[e-1] : 1'b1;
      tick();
      chk($sformatf("bounce_e%0d", e), step_clk, (e >= 12) ? 1 : 0);
    end
    chk("bounce_rises", rises - r0, 1);
    btn_step = 1'b0;
    repeat (10) tick();
    chk("bounce_settle", step_clk, 0);

    // Button held through reset
    r0 = rises;
    Reset = 1'b1; btn_step = 1'b1;
    repeat (3) tick();
    chk("hold_rst_step", step_clk, 0);
    Reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("hold_e6", step_clk, 0);
      if (k == 7) chk("hold_e7", step_clk, 1);
    end
    chk("hold_rises", rises - r0, 1);
    btn_step = 1'b0;
    repeat (10) tick();

    // Display mode 00: word 0x0408
    mode = 2'b00; curPC = 32'h0000_0004; nextPC = 32'h0000_0008;
    wait_wrap();
    dig("m0_d0", 4'b1110, 8'h80);
    tick(); tick(); dig("m0_d1", 4'b1101, 8'hC0);
    tick(); tick(); dig("m0_d2", 4'b1011, 8'h99);
    tick(); tick(); dig("m0_d3", 4'b0111, 8'hC0);

    // Mode 11: word 0x1AF3, mode changed back to 00 mid-frame
    mode = 2'b11; Result = 32'h1A; DBData = 32'hF3;
    wait_wrap();
    dig("m3_d0", 4'b1110, 8'hB0);
    mode = 2'b00;
    tick(); tick(); dig("m3_d1", 4'b1101, 8'h8E);
    tick(); tick(); dig("m3_d2", 4'b1011, 8'h88);
    tick(); tick(); dig("m3_d3", 4'b0111, 8'hF9);
    tick(); tick(); dig("m3_next_d0", 4'b1110, 8'h80);

`ifdef CPU_MONITOR_AUTO_EN
    // Auto-run: toggles every 3 edges, db wins on the edge after run_auto drops
    run_auto = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("auto_e%0d", e), step_clk, (e / 3) % 2);
    end
    run_auto = 1'b0;
    tick();
    chk("auto_off", step_clk, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
